// File: rtl/dcache_pkg.sv
// dcache_pkg: shared widths, address-field helpers and controller states for the data cache
package dcache_pkg;
   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;
   localparam int INDEX_W = 3;
   localparam int OFFSET_W = 2;
   localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
   localparam int SETS = 1 << INDEX_W;
   localparam int BLOCK = 1 << OFFSET_W;
   localparam int INDEX_LSB = OFFSET_W;
   localparam int TAG_LSB = OFFSET_W + INDEX_W;
   typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;
   function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
      return a[TAG_LSB +: TAG_W];
   endfunction
   function automatic logic [INDEX_W-1:0] index_of(input logic [ADDR_W-1:0] a);
      return a[INDEX_LSB +: INDEX_W];
   endfunction
   function automatic logic [OFFSET_W-1:0] offset_of(input logic [ADDR_W-1:0] a);
      return a[OFFSET_W-1:0];
   endfunction
endpackage

// File: rtl/dcache_storage.sv
// dcache_storage: tag/valid/dirty/data arrays, synchronous write, asynchronous read, cleared on reset
module dcache_storage
   import dcache_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst,
   input  logic [INDEX_W-1:0]            index,
   input  logic                          data_we,
   input  logic [OFFSET_W-1:0]           data_off,
   input  logic [DATA_W-1:0]             data_in,
   input  logic                          dirty_set,
   input  logic                          fill_we,
   input  logic [TAG_W-1:0]              tag_in,
   output logic                          valid,
   output logic                          dirty,
   output logic [TAG_W-1:0]              tag,
   output logic [BLOCK-1:0][DATA_W-1:0]  block
);
   logic [SETS-1:0] valid_q, dirty_q;
   logic [TAG_W-1:0] tag_q [SETS];
   logic [BLOCK-1:0][DATA_W-1:0] data_q [SETS];
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         dirty_q <= '0;
         tag_q <= '{default: '0};
         data_q <= '{default: '0};
      end else begin
         if (fill_we) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
            tag_q[index] <= tag_in;
         end else if (dirty_set) dirty_q[index] <= 1'b1;
         if (data_we) data_q[index][data_off] <= data_in;
      end
   end
   assign valid = valid_q[index];
   assign dirty = dirty_q[index];
   assign tag = tag_q[index];
   assign block = data_q[index];
endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped write-back write-allocate cache with byte-serial miss handling
module dcache_controller
   import dcache_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic               read,
   input  logic               write,
   input  logic [ADDR_W-1:0]  address,
   input  logic [DATA_W-1:0]  writedata,
   output logic [DATA_W-1:0]  readdata,
   output logic               busywait,
   output logic               mem_read,
   output logic               mem_write,
   output logic [ADDR_W-1:0]  mem_address,
   output logic [DATA_W-1:0]  mem_writedata,
   input  logic [DATA_W-1:0]  mem_readdata,
   input  logic               mem_busywait
);
   state_t state, state_n;
   logic [OFFSET_W-1:0] k;
   logic gap, req, hit, done, valid, dirty, data_we, dirty_set, fill_we;
   logic [TAG_W-1:0] tag;
   logic [BLOCK-1:0][DATA_W-1:0] block;
   logic [INDEX_W-1:0] index;
   assign index = index_of(address);
   assign req = read ^ write;
   assign hit = valid && tag == tag_of(address);
   assign busywait = req && !hit;
   assign readdata = (read && !write && hit) ? block[offset_of(address)] : '0;
   // a byte finishes when the request is up (not the gap cycle) and memory is not busy
   assign done = !gap && !mem_busywait && (state == WRITEBACK || state == FETCH);
   assign dirty_set = write && !read && hit && state == IDLE;
   assign data_we = dirty_set || (done && state == FETCH);
   dcache_storage u_storage (
      .clk(clock),
      .rst(reset),
      .index(index),
      .data_we(data_we),
      .data_off(state == FETCH ? k : offset_of(address)),
      .data_in(state == FETCH ? mem_readdata : writedata),
      .dirty_set(dirty_set),
      .fill_we(fill_we),
      .tag_in(tag_of(address)),
      .valid(valid),
      .dirty(dirty),
      .tag(tag),
      .block(block)
   );
   always_comb begin
      state_n = state;
      mem_read = 1'b0;
      mem_write = 1'b0;
      mem_address = '0;
      mem_writedata = '0;
      fill_we = 1'b0;
      case (state)
         IDLE: if (busywait) state_n = (valid && dirty) ? WRITEBACK : FETCH;
         WRITEBACK: begin
            mem_write = !gap;
            mem_address = {tag, index, k};
            mem_writedata = block[k];
            if (done && k == '1) state_n = FETCH;
         end
         FETCH: begin
            mem_read = !gap;
            mem_address = {tag_of(address), index, k};
            if (done && k == '1) state_n = UPDATE;
         end
         default: begin
            fill_we = 1'b1;
            state_n = IDLE;
         end
      endcase
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         k <= '0;
         gap <= 1'b0;
      end else begin
         state <= state_n;
         gap <= done;
         if (done) k <= k + 1'b1;
      end
   end
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: randomized scoreboard bench against a set-level cache/memory reference model
module tb_dcache_controller;
   logic clock = 1'b0;
   logic reset, read, write, busywait, mem_read, mem_write, mem_busywait;
   logic [7:0] address, writedata, readdata, mem_address, mem_writedata, mem_readdata;
   always #5 clock = ~clock;

   dcache_controller dut (
      .clock(clock), .reset(reset), .read(read), .write(write),
      .address(address), .writedata(writedata), .readdata(readdata),
      .busywait(busywait), .mem_read(mem_read), .mem_write(mem_write),
      .mem_address(mem_address), .mem_writedata(mem_writedata),
      .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
   );

   typedef struct { bit wr; logic [7:0] addr; logic [7:0] data; } mop_t;
   typedef struct { bit stall; logic [7:0] data; } acc_t;
   mop_t exp_mem[$];
   acc_t exp_acc[$];

   logic [7:0] mem [256];
   logic [7:0] ref_mem [256];
   bit ref_valid [8];
   bit ref_dirty [8];
   logic [2:0] ref_tag [8];
   logic [7:0] ref_data [8][4];
   int checks = 0, errors = 0;
   int wcnt = 0, lat = 1, mem_done = 0;
   bit quiet = 0, stalled = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // memory device: random 0..2 busy cycles per byte
   assign mem_busywait = (mem_read || mem_write) && wcnt < lat;
   assign mem_readdata = mem[mem_address];
   always @(posedge clock) begin
      if ((mem_read || mem_write) && !mem_busywait) begin
         if (mem_write) mem[mem_address] = mem_writedata;
         wcnt <= 0;
         lat <= $urandom_range(0, 2);
         mem_done <= mem_done + 1;
      end else if (mem_read || mem_write) wcnt <= wcnt + 1;
      else wcnt <= 0;
   end

   // monitor: memory transfers and CPU access completions against the queues
   always @(negedge clock) begin
      if (reset || quiet) stalled = 0;
      else begin
         if (mem_read || mem_write) chk("mem_exclusive", {31'b0, mem_read && mem_write}, 0);
         if ((mem_read || mem_write) && !mem_busywait) begin
            if (exp_mem.size() == 0) chk("mem_unexpected", {24'b0, mem_address}, 32'hffff_ffff);
            else begin
               mop_t m;
               m = exp_mem.pop_front();
               chk("mem_kind", {31'b0, mem_write}, {31'b0, m.wr});
               chk("mem_addr", {24'b0, mem_address}, {24'b0, m.addr});
               if (m.wr) chk("mem_wdata", {24'b0, mem_writedata}, {24'b0, m.data});
               else chk("mem_rdata", {24'b0, mem_readdata}, {24'b0, m.data});
            end
         end
         if (read ^ write) begin
            if (busywait) stalled = 1;
            else if (exp_acc.size() == 0) chk("acc_unexpected", {24'b0, address}, 32'hffff_ffff);
            else begin
               acc_t e;
               e = exp_acc.pop_front();
               chk("stall", {31'b0, stalled}, {31'b0, e.stall});
               chk("readdata", {24'b0, readdata}, {24'b0, e.data});
               stalled = 0;
            end
         end
      end
   end

   // reference model: whole-block view of a direct-mapped write-back cache
   task automatic model(bit rd, bit wr, logic [7:0] a, logic [7:0] d);
      logic [2:0] s, t;
      logic [1:0] o, kb;
      logic [7:0] ma;
      bit hit;
      s = a[4:2]; t = a[7:5]; o = a[1:0];
      if (rd == wr) return;
      hit = ref_valid[s] && ref_tag[s] == t;
      if (!hit) begin
         if (ref_valid[s] && ref_dirty[s])
            for (int k = 0; k < 4; k++) begin
               kb = k[1:0];
               ma = {ref_tag[s], s, kb};
               exp_mem.push_back('{1'b1, ma, ref_data[s][k]});
               ref_mem[ma] = ref_data[s][k];
            end
         for (int k = 0; k < 4; k++) begin
            kb = k[1:0];
            ma = {t, s, kb};
            exp_mem.push_back('{1'b0, ma, ref_mem[ma]});
            ref_data[s][k] = ref_mem[ma];
         end
         ref_valid[s] = 1; ref_tag[s] = t; ref_dirty[s] = 0;
      end
      if (wr) begin
         ref_data[s][o] = d;
         ref_dirty[s] = 1;
      end
      exp_acc.push_back('{!hit, rd ? ref_data[s][o] : 8'h00});
   endtask

   task automatic access(bit rd, bit wr, logic [7:0] a, logic [7:0] d);
      bit ok;
      model(rd, wr, a, d);
      read = rd; write = wr; address = a; writedata = d;
      ok = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clock);
         if (!busywait) begin ok = 1; break; end
      end
      if (!ok) chk("access_timeout", {24'b0, a}, 32'hffff_ffff);
      @(posedge clock); #1;
      read = 0; write = 0;
   endtask

   initial begin
      logic [7:0] a, saved80;
      int r, base, diffs;
      bit ok;
      reset = 1; read = 0; write = 0; address = 0; writedata = 0;
      for (int i = 0; i < 256; i++) begin
         mem[i] = 8'($urandom);
         ref_mem[i] = mem[i];
      end
      for (int i = 0; i < 4; i++) begin
         mem[4 + i] = 8'(8'h11 * (i + 1));
         ref_mem[4 + i] = mem[4 + i];
      end
      for (int i = 0; i < 8; i++) begin ref_valid[i] = 0; ref_dirty[i] = 0; end
      saved80 = mem[8'h80];
      repeat (2) @(posedge clock);
      #1 reset = 0;
      @(negedge clock);
      chk("rst_busywait", {31'b0, busywait}, 0);
      chk("rst_mem_read", {31'b0, mem_read}, 0);
      chk("rst_mem_write", {31'b0, mem_write}, 0);
      chk("rst_readdata", {24'b0, readdata}, 0);
      chk("rst_mem_address", {24'b0, mem_address}, 0);
      chk("rst_mem_writedata", {24'b0, mem_writedata}, 0);
      @(posedge clock); #1;

      access(1, 0, 8'h04, 0);
      access(1, 0, 8'h06, 0);
      access(0, 1, 8'h05, 8'hAA);
      access(1, 0, 8'h05, 0);
      chk("mem05_before_evict", {24'b0, mem[8'h05]}, 32'h22);
      access(1, 0, 8'h24, 0);
      chk("mem05_after_evict", {24'b0, mem[8'h05]}, 32'hAA);
      access(0, 1, 8'h80, 8'h5C);
      chk("mem80_unchanged", {24'b0, mem[8'h80]}, {24'b0, saved80});

      // reset while fetching byte 2 of a clean miss
      quiet = 1;
      base = mem_done;
      read = 1; address = 8'h48;
      ok = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clock);
         if (mem_done == base + 2 && mem_read) begin ok = 1; break; end
      end
      chk("fetch_k2_reached", {31'b0, ok}, 1);
      reset = 1; read = 0;
      @(posedge clock); #1 reset = 0;
      @(negedge clock);
      chk("post_reset_mem_read", {31'b0, mem_read}, 0);
      chk("post_reset_busywait", {31'b0, busywait}, 0);
      for (int i = 0; i < 8; i++) begin ref_valid[i] = 0; ref_dirty[i] = 0; end
      exp_mem.delete();
      exp_acc.delete();
      @(posedge clock); #1;
      quiet = 0;
      access(1, 0, 8'h48, 0);

      // read and write together: no request
      base = mem_done;
      read = 1; write = 1; address = 8'h10; writedata = 8'h77;
      repeat (3) begin
         @(negedge clock);
         chk("both_busywait", {31'b0, busywait}, 0);
      end
      @(posedge clock); #1;
      read = 0; write = 0;
      chk("both_no_traffic", mem_done, base);
      access(1, 0, 8'h10, 0);

      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 9);
         a = {3'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
         if (r == 9) begin
            read = 1; write = 1; address = a; writedata = 8'($urandom);
            @(negedge clock);
            chk("rand_both_busywait", {31'b0, busywait}, 0);
            @(posedge clock); #1;
            read = 0; write = 0;
         end else access(r < 5, r >= 5, a, 8'($urandom));
         if ($urandom_range(0, 3) == 0) begin @(posedge clock); #1; end
      end

      repeat (3) @(negedge clock);
      chk("mem_queue_drained", exp_mem.size(), 0);
      chk("acc_queue_drained", exp_acc.size(), 0);
      diffs = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
      chk("final_memory", diffs, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache controller between the CPU load/store path and the 256x8 byte-wide data memory.
- Holds 8 blocks of 4 bytes. Hits are served without a stall.
- On a miss, stalls the CPU, writes back a dirty victim byte-by-byte, refills the block byte-by-byte, then serves the access.

Parameters:
- ADDR_W, 8, CPU and memory byte-address width.
- DATA_W, 8, data word width (one byte).
- INDEX_W, 3, set index bits (8 sets).
- OFFSET_W, 2, byte-offset bits (4-byte blocks); tag width = ADDR_W-INDEX_W-OFFSET_W = 3.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- read  in  1  CPU load request, held until busywait is low.
- write  in  1  CPU store request, held until busywait is low.
- address  in  8  CPU byte address {tag[7:5], index[4:2], offset[1:0]}.
- writedata  in  8  CPU store data.
- readdata  out  8  CPU load data.
- busywait  out  1  CPU stall.
- mem_read  out  1  data-memory read request.
- mem_write  out  1  data-memory write request.
- mem_address  out  8  data-memory byte address.
- mem_writedata  out  8  data-memory write data.
- mem_readdata  in  8  data-memory read data.
- mem_busywait  in  1  data-memory busy.

Behaviour:
- Reset (sync, active-high): all valid and dirty bits cleared; state IDLE; byte counter 0; busywait, mem_read, mem_write = 0; readdata, mem_address, mem_writedata = 0. Reset mid-miss abandons the transfer: the memory request drops on the next cycle and the partially refilled block stays invalid.
- Hit: valid[index] and tag match. Combinational from the request.
- Read hit: readdata = data[index][offset] in the same cycle; busywait = 0.
- Write hit: busywait = 0; byte written and dirty[index] set at the next posedge.
- read and write both high: treated as no request; busywait = 0; no state change.
- Miss: busywait rises combinationally in the request cycle and stays high until the access hits.
- FSM state IDLE: on miss, go to WRITEBACK if valid and dirty, else FETCH. Byte counter = 0.
- FSM state WRITEBACK: for k = 0..3, drive mem_write = 1, mem_address = {old_tag, index, k}, mem_writedata = data[index][k].
  - A byte completes at the first posedge where mem_busywait = 0 and mem_write was asserted in the previous cycle.
  - Controller then deasserts mem_write for exactly one cycle (gap), increments k, and reissues.
  - After k = 3 completes, go to FETCH.
- FSM state FETCH: same handshake with mem_read, mem_address = {new_tag, index, k}. mem_readdata is captured into data[index][k] at the completion posedge. After k = 3, go to UPDATE.
- FSM state UPDATE: one cycle; writes tag, sets valid = 1, dirty = 0; go to IDLE. The retried access then hits (read: data same cycle; write: dirty set).
- Byte counter is 2 bits and wraps 3→0 at the end of each phase.
- mem_read and mem_write are never high together. Both are 0 in IDLE and UPDATE.
- CPU address and data must be stable while busywait = 1. The controller does not latch them.

Decomposition:
- Package dcache_pkg holds:
  - the state enum {IDLE, WRITEBACK, FETCH, UPDATE};
  - ADDR_W, DATA_W, INDEX_W, OFFSET_W, TAG_W;
  - field-extract helper constants for tag, index and offset.
- One sub-module, dcache_storage, holds the tag/valid/dirty/data arrays: synchronous write, asynchronous read, synchronous clear on reset.
- FSM, counter and hit logic live in dcache_controller.

Test Plan:
- Reset, then read 0x04 (memory preset 0x04..0x07 = 11,22,33,44): busywait high; 4 mem_reads to 0x04..0x07, no mem_write. After UPDATE, readdata = 0x11 and busywait falls. A following read of 0x06 gives 0x33 with busywait never high.
- Write 0xAA to 0x05 (hit), then read 0x05 → 0xAA, zero stall. Memory[0x05] still 0x22.
- After the previous case, read 0x24 (same index 1, tag 1, dirty victim) → mem_writes to 0x04..0x07 with data 11,AA,33,44, then mem_reads 0x24..0x27. Final memory[0x05] = 0xAA.
- Write miss to 0x80 with data 0x5C, clean set → fetch 0x80..0x83, then the write hits. Dirty set; memory[0x80] unchanged until eviction.
- Assert reset during FETCH at k = 2: mem_read is 0 the cycle after reset. Re-reading the same address performs a full 4-byte refill.
- read = write = 1 at 0x10: busywait stays 0, no memory traffic, no array change.
